// File: rtl/interrupt_controller.sv
// ---------------------------------------------------------------------------
// interrupt_controller
//
// Collects interrupt requests from NDEV memory-mapped devices, latches their
// rising edges into sticky pending bits, applies a software-writable enable
// mask, and picks one winner round-robin. The winner is presented to the
// system register file as inta/idn. Further interrupts are held off until the
// handler commits RETI.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   irq        per-device request lines (rising edge is significant)
//   intaTaken  pipeline accepted the interrupt this cycle
//   isReti     RETI instruction commits this cycle
//   maskWrtEn  load maskIn[NDEV-1:0] into the enable mask
//   maskIn     new mask value
//   inta       registered interrupt request
//   idn        winning device number (zero-extended), 0 unless requesting
//   ack        one-hot, one-cycle acknowledge pulse to the serviced device
//   pending    sticky pending bits
//   mask       current enable mask
//   busy       an interrupt is being serviced
// ---------------------------------------------------------------------------
module interrupt_controller #(
    parameter int              DBITS      = 32,
    parameter int              NDEV       = 4,
    parameter logic [NDEV-1:0] MASK_RESET = {NDEV{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NDEV-1:0]  irq,
    input  logic             intaTaken,
    input  logic             isReti,
    input  logic             maskWrtEn,
    input  logic [DBITS-1:0] maskIn,
    output logic             inta,
    output logic [DBITS-1:0] idn,
    output logic [NDEV-1:0]  ack,
    output logic [NDEV-1:0]  pending,
    output logic [NDEV-1:0]  mask,
    output logic             busy
);

    localparam int PTRW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } stateType;

    stateType        stateReg, stateNext;
    logic [PTRW-1:0] winReg, winNext;
    logic [PTRW-1:0] rrPtrReg, rrPtrNext;
    logic [NDEV-1:0] irqPrevReg;
    logic [NDEV-1:0] pendingReg, pendingNext;
    logic [NDEV-1:0] maskReg;
    logic [NDEV-1:0] ackReg, ackNext;
    logic            intaReg;
    logic            busyReg;

    logic [NDEV-1:0] eligible;
    logic [NDEV-1:0] rise;
    logic [PTRW-1:0] pickIdx;
    logic            pickFound;

    // Only the low NDEV bits of the mask bus are meaningful.
    logic unusedMaskBits;
    assign unusedMaskBits = &{1'b0, maskIn[DBITS-1:NDEV]};

    assign eligible = pendingReg & maskReg;
    assign rise     = irq & ~irqPrevReg;

    // Pending bits: a new rising edge beats a same-edge acknowledge clear,
    // so a device that re-requests exactly as it is acked is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < NDEV; gi++) begin : gPending
            assign pendingNext[gi] = rise[gi] | (pendingReg[gi] & ~ackNext[gi]);
        end
    endgenerate

    // Round-robin pick: first eligible index scanning upward from rrPtr,
    // wrapping modulo NDEV.
    always_comb begin
        int              cand;
        logic [PTRW-1:0] candIdx;
        pickIdx   = rrPtrReg;
        pickFound = 1'b0;
        cand      = 0;
        candIdx   = '0;
        for (int k = 0; k < NDEV; k++) begin
            cand    = (int'(rrPtrReg) + k) % NDEV;
            candIdx = PTRW'(cand);
            if (!pickFound && eligible[candIdx]) begin
                pickFound = 1'b1;
                pickIdx   = candIdx;
            end
        end
    end

    // Next-state logic. The withdraw test looks at the current mask, so a
    // mask write landing on the same edge as intaTaken cannot pre-empt the take.
    always_comb begin
        stateNext = stateReg;
        winNext   = winReg;
        rrPtrNext = rrPtrReg;
        ackNext   = '0;
        case (stateReg)
            IDLE: begin
                if (pickFound) begin
                    winNext   = pickIdx;
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (intaTaken) begin
                    ackNext[winReg] = 1'b1;
                    rrPtrNext = (winReg == PTRW'(NDEV - 1)) ? '0 : winReg + PTRW'(1);
                    stateNext = SERVICE;
                end else if (!eligible[winReg]) begin
                    stateNext = IDLE;
                end
            end
            SERVICE: begin
                if (isReti) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg   <= IDLE;
            winReg     <= '0;
            rrPtrReg   <= '0;
            irqPrevReg <= '0;
            pendingReg <= '0;
            maskReg    <= MASK_RESET;
            ackReg     <= '0;
            intaReg    <= 1'b0;
            busyReg    <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            winReg     <= winNext;
            rrPtrReg   <= rrPtrNext;
            irqPrevReg <= irq;
            pendingReg <= pendingNext;
            if (maskWrtEn) begin
                maskReg <= maskIn[NDEV-1:0];
            end
            ackReg     <= ackNext;
            // inta/busy are registered copies of the next state so they track
            // the state register exactly.
            intaReg    <= (stateNext == REQ);
            busyReg    <= (stateNext == SERVICE);
        end
    end

    assign inta    = intaReg;
    assign busy    = busyReg;
    assign ack     = ackReg;
    assign pending = pendingReg;
    assign mask    = maskReg;
    assign idn     = (stateReg == REQ) ? DBITS'(winReg) : '0;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Arbitrates interrupt requests from up to NDEV memory-mapped devices (timer, keys, switches, ...) and sequences the interrupt handshake with the pipeline and system register file. Captures device request edges into sticky pending bits, applies a software-writable enable mask, and picks one winner round-robin. It drives the interrupt request and device number (inta/idn) into the system register file. It then holds off further interrupts until the handler's RETI.

## Interface
- DBITS, 32, datapath width; width of idn and mask bus
- NDEV, 4, number of interrupt sources (2..16)
- MASK_RESET, all ones (NDEV bits), enable-mask value after reset

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; one clock; all state cleared immediately on assertion
- irq  in  NDEV  per-device request lines, level; only the rising edge is significant
- intaTaken  in  1  pipeline/system register file accepted the interrupt this cycle (equals the intaSig from the system register file)
- isReti  in  1  RETI instruction is committing this cycle
- maskWrtEn  in  1  write maskIn into the enable mask at this edge
- maskIn  in  DBITS  new mask value; bits [NDEV-1:0] used
- inta  out  1  interrupt request to the system register file (registered)
- idn  out  DBITS  winning device number, zero-extended; valid while inta=1, else 0
- ack  out  NDEV  one-hot, one-cycle pulse to the serviced device
- pending  out  NDEV  current sticky pending bits
- mask  out  NDEV  current enable mask
- busy  out  1  an interrupt is being serviced (state SERVICE)

## Operation
- Edge capture: irqPrev is irq registered each cycle. pending[i] sets at any edge where irq[i]=1 and irqPrev[i]=0. It clears only at the acknowledge edge for device i. If a set and a clear for the same bit occur at the same edge, the set wins.
- eligible = pending & mask.
- Round-robin: the rrPtr register (log2 NDEV bits) resets to 0. The winner is the first set eligible index scanning rrPtr, rrPtr+1, ..., wrapping modulo NDEV. On acknowledge, rrPtr is set to (winner+1) mod NDEV.
- FSM (registered state, winner register win):
  - IDLE: inta=0, idn=0. If eligible≠0, load win and go to REQ. Otherwise stay.
  - REQ: inta=1, idn=win.
    - If intaTaken=1, clear pending[win], pulse ack[win], update rrPtr, and go to SERVICE.
    - Else if eligible[win]=0 (masked off by a write), withdraw and go to IDLE. No ack is issued and pending is kept.
    - Else stay in REQ; win does not change while waiting.
  - SERVICE: inta=0, busy=1. If isReti=1, go to IDLE. New edges keep accumulating in pending.
- isReti outside SERVICE is ignored. intaTaken outside REQ is ignored.
- Mask: the mask register loads maskIn[NDEV-1:0] when maskWrtEn=1, in any state. If intaTaken and a mask write that clears win arrive at the same edge, the take wins.
- The block has no knowledge of PCS. If the pipeline never asserts intaTaken (interrupts disabled), the block remains in REQ indefinitely.

## Timing
- Reset values: state=IDLE, inta=0, idn=0, ack=0, pending=0, irqPrev=0, rrPtr=0, busy=0, mask=MASK_RESET.
- irq rising at edge N (first sampled high) → pending visible after edge N. If the device is enabled and the state is IDLE, state=REQ and inta=1 after edge N+1. Minimum latency is 2 cycles.
- ack is high for exactly the cycle after the intaTaken edge, coincident with busy=1.
- After the isReti edge, state=IDLE. If eligible≠0, inta re-asserts 1 cycle later (IDLE → REQ takes one edge).
- All outputs are driven from registers except idn, which is a mux of win gated by state==REQ.
- Reset asserted mid-REQ or mid-SERVICE drops inta/busy/ack to 0 immediately and discards pending.

## Test plan
- Reset, then irq=4'b0100 rising at edge 3 → pending=4'b0100 after edge 3, inta=1 with idn=2 after edge 4. Assert intaTaken at edge 6 → ack=4'b0100 for one cycle, busy=1, pending=0. Assert isReti at edge 9 → IDLE with inta=0.
- irq[0] and irq[3] rise at the same edge, rrPtr=0 → device 0 serviced first, rrPtr=1. After RETI, device 3 is requested (idn=3) one cycle after IDLE.
- Round-robin fairness: keep re-pulsing irq[0] and irq[1] every service cycle → winners alternate 0,1,0,1. Neither device is starved.
- mask=4'b1110, irq[0] rises → pending[0]=1, inta stays 0. Write mask=4'b1111 → inta=1, idn=0 two cycles later. Mask cleared while in REQ without intaTaken → withdraw to IDLE, pending[0] still 1, no ack.
- In SERVICE, irq[2] rises and intaTaken is pulsed spuriously → no ack and inta=0 until isReti. The same edge as the ack for device 2 also carries a new rising edge on irq[2] → pending[2] remains 1.
- Assert reset asynchronously mid-REQ (between clock edges) → inta, busy, pending and rrPtr are 0 before the next clk edge, and mask equals MASK_RESET.
